uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter and its baud_tick generator among NUM_REQ byte requesters.
- Selects a requester round-robin and accepts its byte through a valid/ready handshake.
- Drives the transmitter's start, data_in and p_sel inputs, then counts baud ticks so the next frame is not launched until the current one has finished.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- GUARD_TICKS, 1: extra idle baud ticks inserted after each frame (0..15).
- IDW, 2: width of grant_id; must satisfy 2**IDW >= NUM_REQ.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i has a byte pending.
- req_data  in  8*NUM_REQ  byte of requester i is bits [8i+7:8i].
- req_par  in  NUM_REQ  bit i: parity select for requester i's frame.
- req_ready  out  NUM_REQ  one-hot, single-cycle acceptance pulse.
- baud_tick  in  1  one-clk pulse per bit period, from the shared baud generator.
- tx_start  out  1  start strobe to the transmitter.
- tx_data  out  8  byte to the transmitter.
- tx_p_sel  out  1  parity select to the transmitter.
- busy  out  1  high while a frame is being sequenced.
- grant_id  out  IDW  index of the current or last granted requester.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE.
  - req_ready=0, tx_start=0, tx_data=8'h00, tx_p_sel=0, busy=0, grant_id=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Tick counter = 0.
- Reset is honoured in any state, including mid-frame. The frame is abandoned and no req_ready is issued afterwards for it.
- States: IDLE, LAUNCH, FRAME.
- IDLE:
  - If any req_valid bit is high, winner = first set bit searching (last+1) mod NUM_REQ upward with wrap.
  - In the same cycle: req_ready[winner]=1 for exactly one clk (combinational from state and valid, so the transfer completes in that cycle).
  - Registered at that edge: tx_data, tx_p_sel, grant_id=winner, last=winner. Next state is LAUNCH; busy=1 from the next cycle.
  - No valid bits: remain in IDLE, req_ready=0.
- LAUNCH:
  - tx_start=1, held until the first baud_tick seen in this state.
  - On that tick: tx_start=0, counter=1, go to FRAME.
- FRAME:
  - Counter increments on each baud_tick.
  - Frame length FL = 10 (start + 8 data + stop) if tx_p_sel=0, or 11 if tx_p_sel=1.
  - When counter reaches FL+GUARD_TICKS on a baud_tick: go to IDLE, busy=0 the next cycle.
- tx_data and tx_p_sel are held stable from LAUNCH until the next acceptance. They are not modified in FRAME.
- Changes to req_valid or req_data while busy have no effect on the current frame.
- Requesters deassert valid only after ready. A valid withdrawn before grant is simply not selected.
- Minimum gap between acceptances:
  - One IDLE cycle.
  - Plus the wait for the first baud_tick in LAUNCH.
  - Plus FL+GUARD_TICKS ticks.
- baud_tick high in the same cycle as acceptance is ignored; counting starts in LAUNCH.
- Counter width is 5 bits; it never wraps given the parameter ranges.

Optional Feature:
- Macro: UART_ARB_FIXED_PRIORITY_EN.
- Defined: the winner is the lowest-index valid requester. The round-robin pointer is not used; grant_id is still updated.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset mid-frame:
  - Stimulus: rst=1 for 5 clks during FRAME of a byte from requester 1.
  - Required: next cycle tx_start=0, busy=0, tx_data=8'h00, grant_id=0, req_ready=0.
  - Required after release: requester 0 wins first.
- Single requester, no parity:
  - Stimulus: req_valid=4'b0001, data 8'hCC, par=0, baud_tick every 4 clks, GUARD_TICKS=1.
  - Required: req_ready[0] pulses exactly once.
  - Required: tx_start high until the first tick; busy high for 11 ticks after LAUNCH; tx_data=8'hCC throughout.
- Parity frame length:
  - Stimulus: requester 2 sends 8'hAD with par=1.
  - Required: busy spans 12 ticks (11+1 guard); tx_p_sel=1 throughout.
- Round-robin fairness:
  - Stimulus: all four valid, held continuously, default build.
  - Required: grant order 0,1,2,3,0.
  - Required: each req_ready is one clk wide and no two are high together.
- Fixed-priority build:
  - Stimulus: UART_ARB_FIXED_PRIORITY_EN defined, requesters 0 and 3 continuously valid.
  - Required: requester 0 granted every frame; requester 3 never granted.
- Late request and tick coincidence:
  - Stimulus: requester 1 asserts valid mid-frame of requester 0; baud_tick coincident with acceptance.
  - Required: requester 1 is granted only after busy falls.
  - Required: the coincident tick is not counted; LAUNCH still waits for the next tick.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter and its baud_tick source among
// NUM_REQ byte requesters. One byte is accepted per frame through a
// valid/ready handshake. The transmitter is launched, and baud ticks are
// counted so the next frame cannot start before the current one plus its
// guard ticks has gone out.
// Build option: define UART_ARB_FIXED_PRIORITY_EN to make the lowest-index
// valid requester win, instead of using round-robin.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GUARD_TICKS = 1,
  parameter int IDW         = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_par,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 baud_tick,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 tx_p_sel,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  typedef enum logic [1:0] {IDLE, LAUNCH, FRAME} state_t;

  state_t             state;
  logic [4:0]         cnt;
  logic [4:0]         frame_end;
  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [7:0]         win_data;
  logic               win_par;
  logic [NUM_REQ-1:0] win_onehot;
  int                 best_d;
  int                 d;
`ifndef UART_ARB_FIXED_PRIORITY_EN
  logic [IDW-1:0]     last;
`endif

  // Winner search: the smallest distance from the search start wins.
  // Round-robin starts at last+1 with wrap. Fixed priority starts at 0.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_data   = '0;
    win_par    = 1'b0;
    win_onehot = '0;
    best_d     = NUM_REQ;
    d          = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
`ifdef UART_ARB_FIXED_PRIORITY_EN
      d = j;
`else
      d = (j + 2*NUM_REQ - int'(last) - 1) % NUM_REQ;
`endif
      if (req_valid[j] && (d < best_d)) begin
        best_d        = d;
        win_found     = 1'b1;
        win_idx       = IDW'(j);
        win_data      = req_data[8*j +: 8];
        win_par       = req_par[j];
        win_onehot    = '0;
        win_onehot[j] = 1'b1;
      end
    end
  end

  // Acceptance pulse. It is held off during reset because the reset edge
  // would discard the byte.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst)
      req_ready = win_onehot;
  end

  // Ticks from the launch tick to the end of the guard period.
  assign frame_end = tx_p_sel ? 5'(11 + GUARD_TICKS) : 5'(10 + GUARD_TICKS);

  // Sequencer: accept, launch the transmitter, then count the frame out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      tx_p_sel <= 1'b0;
      busy     <= 1'b0;
      grant_id <= '0;
      cnt      <= 5'd0;
`ifndef UART_ARB_FIXED_PRIORITY_EN
      last     <= IDW'(NUM_REQ - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          // A tick in the acceptance cycle is deliberately ignored.
          if (win_found) begin
            tx_data  <= win_data;
            tx_p_sel <= win_par;
            grant_id <= win_idx;
`ifndef UART_ARB_FIXED_PRIORITY_EN
            last     <= win_idx;
`endif
            tx_start <= 1'b1;
            busy     <= 1'b1;
            cnt      <= 5'd0;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (baud_tick) begin
            tx_start <= 1'b0;
            cnt      <= 5'd1;
            state    <= FRAME;
          end
        end
        FRAME: begin
          if (baud_tick) begin
            cnt <= cnt + 5'd1;
            if (cnt + 5'd1 == frame_end) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic. The
// reference model is kept at frame level: an acceptance starts a frame that
// needs FL+GUARD ticks, counted from the first tick after acceptance.
module tb_uart_tx_arbiter;
  localparam int NR  = 4;
  localparam int GT  = 1;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_par = '0;
  logic [NR-1:0]   req_ready;
  logic            baud_tick = 1'b0;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_p_sel;
  logic            busy;
  logic [IDW-1:0]  grant_id;

  uart_tx_arbiter #(.NUM_REQ(NR), .GUARD_TICKS(GT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_par(req_par), .req_ready(req_ready), .baud_tick(baud_tick),
    .tx_start(tx_start), .tx_data(tx_data), .tx_p_sel(tx_p_sel),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Frame-level reference model state.
  bit        m_active;
  int        m_ticks, m_need, m_last, m_gid;
  logic [7:0] m_data;
  bit        m_par;
  logic [NR-1:0] m_ready;

  // Observations from the DUT.
  int dut_grants[$];
  int ready_cnt[NR];
  int gnt_busy[NR];
  int busy_ticks;
  int tick_div;
  int cyc;

  function automatic void model_reset();
    m_active = 0; m_ticks = 0; m_need = 0; m_last = NR - 1;
    m_gid = 0; m_data = 8'h00; m_par = 0;
  endfunction

  function automatic int pick(input logic [NR-1:0] v);
    int vv;
    vv = int'(v);
`ifdef UART_ARB_FIXED_PRIORITY_EN
    for (int k = 0; k < NR; k++)
      if (((vv >> k) & 1) == 1) return k;
`else
    for (int k = 1; k <= NR; k++)
      if (((vv >> ((m_last + k) % NR)) & 1) == 1) return (m_last + k) % NR;
`endif
    return -1;
  endfunction

  // One clock: check the acceptance pulse mid-cycle, advance the model at
  // the edge, then check the registered outputs.
  task automatic step();
    int w;
    logic            r_s, t_s;
    logic [8*NR-1:0] d_s;
    logic [NR-1:0]   p_s;
    #1;
    r_s = rst; t_s = baud_tick; d_s = req_data; p_s = req_par;
    w = (m_active || r_s) ? -1 : pick(req_valid);
    m_ready = '0;
    if (w >= 0) m_ready[w] = 1'b1;
    chk("ready", req_ready, m_ready);
    chk("ready_onehot", ($countones(req_ready) > 1), 0);
    if (busy && t_s) busy_ticks++;
    for (int k = 0; k < NR; k++)
      if (req_ready[k] === 1'b1) begin
        ready_cnt[k]++;
        dut_grants.push_back(k);
        gnt_busy[k] = busy;
      end
    @(posedge clk);
    if (r_s) model_reset();
    else if (!m_active) begin
      if (w >= 0) begin
        m_active = 1; m_ticks = 0;
        m_need = (p_s[w] ? 11 : 10) + GT;
        m_data = d_s[8*w +: 8]; m_par = p_s[w];
        m_gid = w; m_last = w;
      end
    end else if (t_s) begin
      m_ticks++;
      if (m_ticks == m_need) m_active = 0;
    end
    #1;
    chk("busy", busy, m_active);
    chk("tx_start", tx_start, (m_active && m_ticks == 0));
    chk("tx_data", tx_data, m_data);
    chk("tx_p_sel", tx_p_sel, m_par);
    chk("grant_id", grant_id, m_gid);
  endtask

  task automatic drive_tick();
    if (tick_div == 0) baud_tick = ($urandom_range(0, 2) == 0);
    else               baud_tick = ((cyc % tick_div) == 0);
    cyc++;
  endtask

  task automatic clear_obs();
    dut_grants.delete();
    foreach (ready_cnt[k]) begin ready_cnt[k] = 0; gnt_busy[k] = -1; end
    busy_ticks = 0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      drive_tick(); step();
      req_valid = req_valid & ~m_ready;
      done = !m_active && (req_valid == '0);
    end
    chk(tag, done, 1);
  endtask

  task automatic collect(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && dut_grants.size() < n; i++) begin
      drive_tick(); step();
    end
    chk(tag, (dut_grants.size() >= n), 1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; baud_tick = 1'b0;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  function automatic int grant_at(input int i);
    return (i < dut_grants.size()) ? dut_grants[i] : -1;
  endfunction

  initial begin
    int exp_rr[5];
    int exp_fp[4];
    model_reset();
    clear_obs();
    cyc = 0; tick_div = 4;
    @(posedge clk); #1;

    // Reset state; valid during reset must not be accepted.
    req_valid = 4'b0101;
    do_reset(2);
    chk("rst_busy", busy, 0);
    chk("rst_data", tx_data, 8'h00);
    req_valid = '0;

    // Single requester, no parity.
    clear_obs();
    req_valid = 4'b0001; req_data[7:0] = 8'hCC; req_par = '0;
    wait_idle("t1_done", 300);
    chk("t1_ready_cnt", ready_cnt[0], 1);
    chk("t1_busy_ticks", busy_ticks, 11);
    chk("t1_data_held", tx_data, 8'hCC);

    // Parity frame from requester 2.
    clear_obs();
    req_valid = 4'b0100; req_data[23:16] = 8'hAD; req_par = 4'b0100;
    wait_idle("t2_done", 300);
    chk("t2_busy_ticks", busy_ticks, 12);
    chk("t2_p_sel", tx_p_sel, 1);
    chk("t2_gid", grant_id, 2);
    req_par = '0;

    // All four held valid continuously.
    do_reset(1);
    clear_obs();
    req_data = $urandom(); req_par = 4'(($urandom() & 15));
    req_valid = 4'b1111;
    collect("t3_collect", 5, 2000);
    req_valid = '0;
    wait_idle("t3_done", 300);
`ifdef UART_ARB_FIXED_PRIORITY_EN
    exp_rr = '{0, 0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 5; i++) chk("t3_order", grant_at(i), exp_rr[i]);
    req_par = '0;

    // Requesters 0 and 3 held valid continuously.
    do_reset(1);
    clear_obs();
    req_valid = 4'b1001;
    collect("t4_collect", 4, 2000);
    req_valid = '0;
    wait_idle("t4_done", 300);
`ifdef UART_ARB_FIXED_PRIORITY_EN
    exp_fp = '{0, 0, 0, 0};
    chk("t4_req3_never", ready_cnt[3], 0);
`else
    exp_fp = '{0, 3, 0, 3};
`endif
    for (int i = 0; i < 4; i++) chk("t4_order", grant_at(i), exp_fp[i]);

    // Late request and a tick coincident with acceptance.
    do_reset(1);
    clear_obs();
    req_valid = 4'b0001; req_data[7:0] = 8'h5A; baud_tick = 1'b1;
    step();
    req_valid = req_valid & ~m_ready;
    baud_tick = 1'b0;
    step();
    chk("t5_start_held", tx_start, 1);
    cyc = 1;
    for (int i = 0; i < 20; i++) begin drive_tick(); step(); end
    req_valid = 4'b0010; req_data[15:8] = 8'h3C;
    wait_idle("t5_done", 400);
    chk("t5_first", grant_at(0), 0);
    chk("t5_second", grant_at(1), 1);
    chk("t5_busy_at_gnt", gnt_busy[1], 0);

    // Reset mid-frame of requester 1.
    do_reset(1);
    clear_obs();
    req_valid = 4'b0010; req_data[15:8] = 8'h77;
    for (int i = 0; i < 200 && !(m_active && m_ticks >= 2); i++) begin
      drive_tick(); step(); req_valid = req_valid & ~m_ready;
    end
    chk("t6_in_frame", (m_active && m_ticks >= 2), 1);
    req_valid = 4'b0011;
    rst = 1'b1;
    step();
    chk("t6_start", tx_start, 0);
    chk("t6_busy", busy, 0);
    chk("t6_data", tx_data, 8'h00);
    chk("t6_gid", grant_id, 0);
    for (int i = 0; i < 4; i++) step();
    chk("t6_no_ready", req_ready, 0);
    rst = 1'b0;
    clear_obs();
    wait_idle("t6_done", 400);
    chk("t6_first_after", grant_at(0), 0);

    // Randomized traffic with irregular ticks and rare resets.
    tick_div = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NR; k++) begin
        if (!req_valid[k]) begin
          req_data[8*k +: 8] = 8'($urandom());
          req_par[k] = 1'($urandom());
          if ($urandom_range(0, 7) == 0) req_valid[k] = 1'b1;
        end else if ($urandom_range(0, 63) == 0) begin
          req_valid[k] = 1'b0;
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      drive_tick(); step();
      req_valid = req_valid & ~m_ready;
    end
    rst = 1'b0;
    req_valid = '0;
    wait_idle("rand_drain", 400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
